// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the byte-serial memory port arbiter: size codes,
// controller states, IO region decode and the byte-count helper.
package mem_port_arbiter_pkg;

    // funct3-style size codes; loads use bit 2 for zero extension
    localparam logic [2:0] SZ_LB  = 3'b000;
    localparam logic [2:0] SZ_LH  = 3'b001;
    localparam logic [2:0] SZ_LW  = 3'b010;
    localparam logic [2:0] SZ_LBU = 3'b100;
    localparam logic [2:0] SZ_LHU = 3'b101;
    localparam logic [2:0] SZ_SB  = 3'b000;
    localparam logic [2:0] SZ_SH  = 3'b001;
    localparam logic [2:0] SZ_SW  = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_TAIL = 2'd2,
        ST_DONE = 2'd3
    } arb_state_e;

    // Reads in this region have side effects, so no byte may be issued twice.
    localparam int         IO_SEL_LSB = 16;
    localparam logic [1:0] IO_REGION  = 2'b11;

    function automatic logic is_io_addr(input logic [31:0] addr);
        return addr[IO_SEL_LSB +: 2] == IO_REGION;
    endfunction

    // Index of the last byte of an access: (1 << code) bytes, clamped to the
    // client data width.
    function automatic logic [1:0] last_byte_idx(input logic [1:0] code, input int max_bytes);
        int n;
        n = 1 << code;
        if (n > max_bytes) n = max_bytes;
        return 2'(n - 1);
    endfunction

endpackage

// File: rtl/mem_rr_arbiter.sv
// Request arbiter: fixed priority (lowest index) or round-robin starting after
// the last winner. Only the last-winner pointer is registered.
module mem_rr_arbiter
#(
    parameter int NCH   = 2,
    parameter int IDX_W = 1
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic [NCH-1:0]   req,
    input  logic             take,
    output logic [NCH-1:0]   gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    int               start_idx;
    int               cand;
    logic             found;

    // Circular search for the first requester from the mode-dependent start.
    always_comb begin
        gnt       = '0;
        gnt_idx   = '0;
        found     = 1'b0;
        cand      = 0;
        start_idx = 0;
        if (mode) start_idx = (int'(ptr_q) + 1) % NCH;
        for (int i = 0; i < NCH; i++) begin
            cand = start_idx + i;
            if (cand >= NCH) cand = cand - NCH;
            if (!found && req[cand]) begin
                found        = 1'b1;
                gnt[cand]    = 1'b1;
                gnt_idx      = IDX_W'(cand);
            end
        end
    end

    // Pointer moves only when the controller actually takes the grant.
    always_comb begin
        ptr_d = ptr_q;
        if (take) ptr_d = gnt_idx;
    end

    // Reset to the highest channel so channel 0 is served first.
    always_ff @(posedge clk) begin
        if (!rst) ptr_q <= IDX_W'(NCH - 1);
        else      ptr_q <= ptr_d;
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Multi-client byte-serial memory port. Grants one client, issues its access
// as single-byte transfers and returns the assembled, extended read data.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no access in flight; grant a requester when rdy is high
// ST_XFER | issue one byte per ready cycle at base+cnt
// ST_TAIL | read only: last byte issued, wait for its capture
// ST_DONE | pulse done for the winner, present rdata, release busy
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int NCH       = 2,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int PRIO_MODE = 0
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rdy,
    input  logic [NCH-1:0]        req_re,
    input  logic [NCH-1:0]        req_we,
    input  logic [NCH*3-1:0]      req_width,
    input  logic [NCH*ADDR_W-1:0] req_addr,
    input  logic [NCH*DATA_W-1:0] req_wdata,
    output logic [DATA_W-1:0]     rdata,
    output logic [NCH-1:0]        done,
    output logic [NCH-1:0]        busy,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_W-1:0]     mem_a,
    output logic                  mem_wr
);

    localparam int NB    = DATA_W / 8;
    localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  win_q, win_d;
    logic              we_q, we_d;
    logic              sext_q, sext_d;
    logic [1:0]        last_q, last_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [NCH-1:0]    busy_q, busy_d;
    logic [ADDR_W-1:0] mem_a_q, mem_a_d;
    logic [7:0]        mem_dout_q, mem_dout_d;
    logic              pend_q, pend_d;
    logic [1:0]        pidx_q, pidx_d;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;

    logic [NCH-1:0]    req;
    logic [NCH-1:0]    gnt;
    logic [IDX_W-1:0]  gnt_idx;
    logic              take;
    logic              issue;
    logic              fin;
    logic [NCH-1:0]    win_oh;
    logic [ADDR_W-1:0] cur_addr;
    logic [7:0]        cur_byte;
    logic              sbit;
    logic [7:0]        fill;
    logic [DATA_W-1:0] ext_data;

    assign req   = req_re | req_we;
    assign take  = (state_q == ST_IDLE) && rdy && (|req);
    assign issue = (state_q == ST_XFER) && rdy;
    assign fin   = (state_q == ST_DONE) && rdy;

    mem_rr_arbiter #(
        .NCH   (NCH),
        .IDX_W (IDX_W)
    ) u_arb (
        .clk     (clk),
        .rst     (rst),
        .mode    (PRIO_MODE != 0),
        .req     (req),
        .take    (take),
        .gnt     (gnt),
        .gnt_idx (gnt_idx)
    );

    // One-hot form of the latched winner, used for done and busy release.
    always_comb begin
        win_oh = '0;
        for (int i = 0; i < NCH; i++) begin
            win_oh[i] = (int'(win_q) == i);
        end
    end

    // Address and write byte of the transfer slot selected by cnt.
    always_comb begin
        cur_addr = base_q + ADDR_W'(cnt_q);
        cur_byte = '0;
        for (int k = 0; k < NB; k++) begin
            if (cnt_q == 2'(k)) cur_byte = wdata_q[8*k +: 8];
        end
    end

    // Controller next state; all latched fields hold unless updated.
    always_comb begin
        state_d    = state_q;
        win_d      = win_q;
        we_d       = we_q;
        sext_d     = sext_q;
        last_d     = last_q;
        base_d     = base_q;
        wdata_d    = wdata_q;
        cnt_d      = cnt_q;
        busy_d     = busy_q;
        mem_a_d    = mem_a_q;
        mem_dout_d = mem_dout_q;
        unique case (state_q)
            ST_IDLE: begin
                if (take) begin
                    win_d   = gnt_idx;
                    we_d    = req_we[gnt_idx];
                    sext_d  = ~req_width[3*int'(gnt_idx) + 2];
                    last_d  = last_byte_idx(req_width[3*int'(gnt_idx) +: 2], NB);
                    base_d  = req_addr[ADDR_W*int'(gnt_idx) +: ADDR_W];
                    wdata_d = req_wdata[DATA_W*int'(gnt_idx) +: DATA_W];
                    busy_d  = busy_q | gnt;
                    cnt_d   = 2'd0;
                    state_d = ST_XFER;
                end
            end
            ST_XFER: begin
                if (rdy) begin
                    mem_a_d    = cur_addr;
                    mem_dout_d = cur_byte;
                    if (cnt_q == last_q) state_d = we_q ? ST_DONE : ST_TAIL;
                    else                 cnt_d   = cnt_q + 2'd1;
                end
            end
            ST_TAIL: begin
                if (rdy) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rdy) begin
                    busy_d  = busy_q & ~win_oh;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Read capture: a byte issued with rdy high is stored on the next edge,
    // independent of rdy, so a pause never drops or repeats a read.
    always_comb begin
        pend_d = issue && !we_q;
        pidx_d = issue ? cnt_q : pidx_q;
        rbuf_d = rbuf_q;
        if (pend_q) begin
            for (int k = 0; k < NB; k++) begin
                if (pidx_q == 2'(k)) rbuf_d[8*k +: 8] = mem_din;
            end
        end
    end

    // Sign or zero extension from the last byte of the access.
    always_comb begin
        sbit = 1'b0;
        for (int k = 0; k < NB; k++) begin
            if (last_q == 2'(k)) sbit = rbuf_q[8*k + 7];
        end
        fill     = {8{sext_q & sbit}};
        ext_data = '0;
        for (int k = 0; k < NB; k++) begin
            ext_data[8*k +: 8] = (2'(k) <= last_q) ? rbuf_q[8*k +: 8] : fill;
        end
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            win_q      <= '0;
            we_q       <= 1'b0;
            sext_q     <= 1'b0;
            last_q     <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            wdata_q    <= '0;
            busy_q     <= '0;
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            pend_q     <= 1'b0;
            pidx_q     <= '0;
            rbuf_q     <= '0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            we_q       <= we_d;
            sext_q     <= sext_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            mem_a_q    <= mem_a_d;
            mem_dout_q <= mem_dout_d;
            pend_q     <= pend_d;
            pidx_q     <= pidx_d;
            rbuf_q     <= rbuf_d;
        end
    end

    // Bus pins show the live slot while issuing and hold the last one otherwise.
    always_comb begin
        mem_wr   = issue && we_q;
        mem_a    = issue ? cur_addr : mem_a_q;
        mem_dout = issue ? cur_byte : mem_dout_q;
        done     = fin ? win_oh : '0;
        rdata    = (fin && !we_q) ? ext_data : '0;
        busy     = busy_q;
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench: a byte-array model predicts every completion and every
// write beat; monitors compare whatever the DUT presents.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              rdy;
    logic [NCH-1:0]    req_re, req_we;
    logic [NCH*3-1:0]  req_width;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;

    logic [DW-1:0]  rdata, rdata_fx;
    logic [NCH-1:0] done, done_fx, busy, busy_fx;
    logic [7:0]     mem_din, mem_din_fx, mem_dout, mem_dout_fx;
    logic [AW-1:0]  mem_a, mem_a_fx;
    logic           mem_wr, mem_wr_fx;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    mem_port_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(1)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_re(req_re), .req_we(req_we), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata), .done(done), .busy(busy),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    mem_port_arbiter #(.NCH(NCH), .ADDR_W(AW), .DATA_W(DW), .PRIO_MODE(0)) dut_fx (
        .clk(clk), .rst(rst), .rdy(rdy),
        .req_re(req_re), .req_we(req_we), .req_width(req_width),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rdata(rdata_fx), .done(done_fx), .busy(busy_fx),
        .mem_din(mem_din_fx), .mem_dout(mem_dout_fx), .mem_a(mem_a_fx), .mem_wr(mem_wr_fx)
    );

    logic [7:0] ram    [0:8191];
    logic [7:0] ram_fx [0:8191];
    logic [7:0] ref_mem[0:8191];

    // Synchronous byte RAMs: data for the address seen at an edge appears after it.
    always @(posedge clk) begin
        if (mem_wr) ram[mem_a[12:0]] <= mem_dout;
        mem_din <= ram[mem_a[12:0]];
    end
    always @(posedge clk) begin
        if (mem_wr_fx) ram_fx[mem_a_fx[12:0]] <= mem_dout_fx;
        mem_din_fx <= ram_fx[mem_a_fx[12:0]];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int ch; logic [31:0] data; int cyc; } resp_t;
    typedef struct { logic [31:0] a; logic [7:0] d; } beat_t;
    resp_t sb_q[$];
    beat_t wb_q[$];
    resp_t mon_e;
    beat_t mon_b;

    // Completion and write-beat monitor for the round-robin instance.
    always @(negedge clk) begin
        if (done !== '0) begin
            if (sb_q.size() == 0) chk("unexpected_done", 64'(done), 64'd0);
            else begin
                mon_e = sb_q.pop_front();
                chk("done_ch", 64'(done), 64'(2'b01 << mon_e.ch));
                chk("rdata", 64'(rdata), 64'(mon_e.data));
                if (mon_e.cyc >= 0) chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
            end
        end
        if (mem_wr !== 1'b0) begin
            if (wb_q.size() == 0) chk("unexpected_write", 64'(mem_a), 64'hFFFF_FFFF_FFFF_FFFF);
            else begin
                mon_b = wb_q.pop_front();
                chk("wr_addr", 64'(mem_a), 64'(mon_b.a));
                chk("wr_byte", 64'(mem_dout), 64'(mon_b.d));
            end
        end
    end

    bit          fx_log = 1'b0;
    int          fx0 = 0, fx1 = 0;
    logic [31:0] fx_exp;

    // Completion log for the fixed-priority instance during the arbitration test.
    always @(negedge clk) begin
        if (fx_log) begin
            if (done_fx[0] === 1'b1) begin
                fx0++;
                chk("fx_rdata", 64'(rdata_fx), 64'(fx_exp));
            end
            if (done_fx[1] === 1'b1) fx1++;
        end
    end

    function automatic int nbytes_of(input logic [2:0] w);
        int n;
        n = 1 << w[1:0];
        return (n > 4) ? 4 : n;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] w);
        int          n;
        logic [63:0] v;
        n = nbytes_of(w);
        v = 64'd0;
        for (int k = 0; k < n; k++) v = v | (64'(ref_mem[13'(a + 32'(k))]) << (8 * k));
        if (!w[2] && v[8*n-1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v[31:0];
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input int n);
        beat_t b;
        for (int k = 0; k < n; k++) begin
            b.a = a + 32'(k);
            b.d = wd[8*k +: 8];
            ref_mem[13'(b.a)] = b.d;
            wb_q.push_back(b);
        end
    endtask

    // An access needs lat+1 cycles with rdy high; done lands on the last of them.
    function automatic int done_cycle(input int lat, input logic [31:0] mask);
        int highs;
        highs = 0;
        for (int i = 0; i < 64; i++) begin
            if (i >= 32 || mask[i]) begin
                highs++;
                if (highs == lat + 1) return i;
            end
        end
        return -1;
    endfunction

    task automatic set_byte(input logic [31:0] a, input logic [7:0] d);
        ram[a[12:0]]     = d;
        ram_fx[a[12:0]]  = d;
        ref_mem[a[12:0]] = d;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_mem_a"}, 64'(mem_a), 64'd0);
        chk({tag, "_mem_dout"}, 64'(mem_dout), 64'd0);
        chk({tag, "_mem_wr"}, 64'(mem_wr), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    // Starts at #1 after a posedge in IDLE; returns at #1 after the posedge
    // that follows the completion.
    task automatic access(input int ch, input logic we, input logic [2:0] w,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] mask, input bit chk_a);
        int          n, lat, c0;
        logic [31:0] exp;
        resp_t       e;
        bit          seen;
        n = nbytes_of(w);
        if (we) begin
            model_write(a, wd, n);
            exp = 32'd0;
            lat = n + 1;
        end else begin
            exp = model_read(a, w);
            lat = n + 2;
        end
        c0     = cyc;
        e.ch   = ch;
        e.data = exp;
        e.cyc  = c0 + done_cycle(lat, mask);
        sb_q.push_back(e);
        req_re[ch]              = !we;
        req_we[ch]              = we;
        req_width[3*ch +: 3]    = w;
        req_addr[AW*ch +: AW]   = a;
        req_wdata[DW*ch +: DW]  = wd;
        rdy  = mask[0];
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (chk_a && !we && i >= 1 && i <= n) begin
                chk("rd_addr", 64'(mem_a), 64'(a + 32'(i - 1)));
                chk("rd_no_wr", 64'(mem_wr), 64'd0);
            end
            if (chk_a && i == 1) chk("busy_set", 64'(busy), 64'(2'b01 << ch));
            if (done[ch] === 1'b1) begin
                seen = 1'b1;
                req_re[ch] = 1'b0;
                req_we[ch] = 1'b0;
                break;
            end
            @(posedge clk);
            #1;
            rdy = (i + 1 >= 32) ? 1'b1 : mask[i + 1];
        end
        if (!seen) begin
            chk("done_timeout", 64'd0, 64'd1);
            req_re[ch] = 1'b0;
            req_we[ch] = 1'b0;
        end
        @(posedge clk);
        #1;
        rdy = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          c0, ndone;
        logic [31:0] a, wd, mask;
        logic [2:0]  w;
        logic        we;
        int          ch;

        for (int i = 0; i < 8192; i++) begin
            ram[i]     = 8'($urandom);
            ram_fx[i]  = ram[i];
            ref_mem[i] = ram[i];
        end
        rst = 1'b0; rdy = 1'b1;
        req_re = '0; req_we = '0; req_width = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;

        // Word read with known bytes
        set_byte(32'h100, 8'h11); set_byte(32'h101, 8'h22);
        set_byte(32'h102, 8'h33); set_byte(32'h103, 8'h84);
        access(0, 1'b0, SZ_LW, 32'h100, 32'h0, 32'hFFFF_FFFF, 1'b1);

        // Byte and halfword extension
        set_byte(32'h200, 8'h80);
        access(1, 1'b0, SZ_LB,  32'h200, 32'h0, 32'hFFFF_FFFF, 1'b1);
        access(0, 1'b0, SZ_LBU, 32'h200, 32'h0, 32'hFFFF_FFFF, 1'b0);
        set_byte(32'h210, 8'h01); set_byte(32'h211, 8'h80);
        access(1, 1'b0, SZ_LH,  32'h210, 32'h0, 32'hFFFF_FFFF, 1'b1);
        access(0, 1'b0, SZ_LHU, 32'h210, 32'h0, 32'hFFFF_FFFF, 1'b0);

        // Word store, read back, and an oversize code clamped to a word
        access(1, 1'b1, SZ_SW, 32'h1000, 32'hDEADBEEF, 32'hFFFF_FFFF, 1'b0);
        access(0, 1'b0, SZ_LW, 32'h1000, 32'h0, 32'hFFFF_FFFF, 1'b0);
        access(0, 1'b0, 3'b011, 32'h1000, 32'h0, 32'hFFFF_FFFF, 1'b0);

        // Three cycles of pause right after the first byte of a word read
        access(0, 1'b0, SZ_LW, 32'h100, 32'h0, ~32'h0000_001C, 1'b0);
        access(1, 1'b1, SZ_SH, 32'h0003_0120, 32'h0000_A55A, ~32'h0000_000A, 1'b0);

        // Reset during the second byte of a word store
        req_we[1] = 1'b1;
        req_width[5:3] = SZ_SW;
        req_addr[2*AW-1:AW] = 32'h1100;
        req_wdata[2*DW-1:DW] = 32'hCAFEF00D;
        model_write(32'h1100, 32'hCAFEF00D, 2);
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_test_busy", 64'(busy), 64'b10);
        @(posedge clk); #1;
        rst = 1'b0;
        req_we[1] = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        check_idle_outputs("midrst");
        @(posedge clk); #1;
        rst = 1'b1;
        access(0, 1'b0, SZ_LW, 32'h1100, 32'h0, 32'hFFFF_FFFF, 1'b1);

        // Arbitration with both channels held continuously, from reset
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        c0 = cyc;
        fx_exp = model_read(32'h300, SZ_LW);
        begin
            resp_t e;
            e.ch = 0; e.data = fx_exp; e.cyc = c0 + 6;  sb_q.push_back(e);
            e.ch = 1; e.data = 32'd0;  e.cyc = c0 + 12; sb_q.push_back(e);
            e.ch = 0; e.data = fx_exp; e.cyc = c0 + 19; sb_q.push_back(e);
            e.ch = 1; e.data = 32'd0;  e.cyc = c0 + 25; sb_q.push_back(e);
        end
        model_write(32'h400, 32'h5A5AA5A5, 4);
        model_write(32'h400, 32'h5A5AA5A5, 4);
        req_re = 2'b01; req_we = 2'b10;
        req_width = {SZ_SW, SZ_LW};
        req_addr  = {32'h400, 32'h300};
        req_wdata = {32'h5A5AA5A5, 32'h0};
        fx_log = 1'b1;
        ndone = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done !== '0) ndone++;
            if (ndone == 4) begin
                req_re = '0; req_we = '0;
                break;
            end
            @(posedge clk); #1;
        end
        req_re = '0; req_we = '0;
        chk("arb_done_count", 64'(ndone), 64'd4);
        repeat (10) @(posedge clk);
        #1;
        fx_log = 1'b0;
        chk("fx_ch0_grants", 64'(fx0), 64'd4);
        chk("fx_ch1_grants", 64'(fx1), 64'd0);

        // Randomised single-client traffic with random pauses
        for (int t = 0; t < 40; t++) begin
            ch = $urandom_range(0, 1);
            we = ($urandom_range(0, 2) == 0);
            if (we) w = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3))};
            else    w = 3'($urandom_range(0, 7));
            a = $urandom & 32'h0003_1FFF;
            if ((t % 4 == 0) && !is_io_addr(a)) a = a | 32'h0003_0000;
            wd = $urandom;
            mask = $urandom | $urandom | $urandom;
            access(ch, we, w, a, wd, mask, 1'b0);
        end

        repeat (3) @(posedge clk);
        chk("sb_drained", 64'(sb_q.size()), 64'd0);
        chk("wb_drained", 64'(wb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
